// File: rtl/pc_ctrl.sv
// Program-counter controller: BOOT/RUN/FAULT sequencing, next-PC selection,
// misaligned-target trapping and a retired-advance counter.
module pc_ctrl #(
  parameter int unsigned    N         = 32,
  parameter logic [N-1:0]   RESET_VEC = '0,
  parameter logic [N-1:0]   TRAP_VEC  = N'(32'h0000_0100),
  parameter int unsigned    CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       pcsel,
  input  logic             brtaken,
  input  logic [N-1:0]     imm,
  input  logic [N-1:0]     rs1,
  input  logic             exc_clr,
  output logic [N-1:0]     pc,
  output logic             pc_valid,
  output logic [N-1:0]     link,
  output logic             exc,
  output logic [N-1:0]     epc,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_e;
  typedef enum logic [1:0] {SEL_SEQ = 2'b00, SEL_BR = 2'b01, SEL_JAL = 2'b10, SEL_JALR = 2'b11} pcsel_e;

  state_e            state_q, state_d;
  logic [N-1:0]      pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              exc_q, exc_d;
  logic [N-1:0]      epc_q, epc_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  pcsel_e       sel;
  logic [N-1:0] seq_tgt;
  logic [N-1:0] rel_tgt;
  logic [N-1:0] jalr_sum;
  logic [N-1:0] target;
  logic         misaligned;

  assign sel      = pcsel_e'(pcsel);
  assign seq_tgt  = pc_q + N'(4);
  assign rel_tgt  = pc_q + imm;
  assign jalr_sum = rs1 + imm;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    target = seq_tgt;
    case (sel)
      SEL_SEQ:  target = seq_tgt;
      SEL_BR:   target = brtaken ? rel_tgt : seq_tgt;
      SEL_JAL:  target = rel_tgt;
      SEL_JALR: target = {jalr_sum[N-1:1], 1'b0};
    endcase
  end

  // Bit 0 can only be set on relative targets; jalr clears it and seq inherits pc alignment.
  assign misaligned = target[1] | (target[0] & ((sel == SEL_BR) | (sel == SEL_JAL)));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    epc_d      = epc_q;
    retired_d  = retired_q;
    exc_d      = 1'b0;
    if (!stall) begin
      case (state_q)
        BOOT: begin
          state_d    = RUN;
          pc_valid_d = 1'b1;
        end
        RUN: begin
          if (misaligned) begin
            pc_d       = TRAP_VEC;
            epc_d      = pc_q;
            exc_d      = 1'b1;
            pc_valid_d = 1'b0;
            state_d    = FAULT;
          end else begin
            pc_d      = target;
            retired_d = retired_q + CNT_W'(1);
          end
        end
        FAULT: begin
          pc_d = TRAP_VEC;
          if (exc_clr) begin
            state_d    = RUN;
            pc_valid_d = 1'b1;
          end
        end
        default: begin
          state_d    = BOOT;
          pc_d       = RESET_VEC;
          pc_valid_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      exc_q      <= 1'b0;
      epc_q      <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      exc_q      <= exc_d;
      epc_q      <= epc_d;
      retired_q  <= retired_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign link     = seq_tgt;
  assign exc      = exc_q;
  assign epc      = epc_q;
  assign retired  = retired_q;

endmodule
